mmio_slot_ctrl: RTL
===================

Name: mmio_slot_ctrl

Overview:
- Registered MMIO front end that sits directly upstream of every slot core, including the 48-bit timer slot.
- Accepts single-beat read/write requests from the processor bus bridge and decodes the slot index.
- Drives the registered per-slot strobes plus the shared cs/read/write/addr/wr_data interface.
- Captures the selected slot's rd_data and returns it with a one-cycle ack.

Parameters:
- N_SLOTS, 32, number of populated slots (1..64); slot indices >= N_SLOTS are unpopulated.
- SLOT_W, 6, width of the slot-index field in mmio_addr.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mmio_req  in  1  request pulse; accepted only when mmio_ready=1.
- mmio_wr  in  1  write request, qualified by mmio_req.
- mmio_rd  in  1  read request, qualified by mmio_req.
- mmio_addr  in  SLOT_W+5  [SLOT_W+4:5]=slot index, [4:0]=slot register address.
- mmio_wr_data  in  32  write data.
- mmio_ready  out  1  controller idle, can accept a request.
- mmio_ack  out  1  one-cycle completion pulse.
- mmio_rd_data  out  32  read data, valid while mmio_ack=1 and held until the next read ack.
- slot_cs  out  N_SLOTS  one-hot chip select, registered.
- slot_read  out  1  shared read strobe, registered.
- slot_write  out  1  shared write strobe, registered.
- slot_addr  out  5  shared register address, registered.
- slot_wr_data  out  32  shared write data, registered.
- slot_rd_data  in  N_SLOTS*32  flattened slot read buses; slot k occupies bits [32k+31:32k]. Each slot bus is combinational from its addr.

Behaviour:
- Reset values:
  - State IDLE; mmio_ready=1.
  - mmio_ack=0; mmio_rd_data=0.
  - slot_cs=0; slot_read=0; slot_write=0; slot_addr=0; slot_wr_data=0.
- FSM states: IDLE, ACCESS, RESP. mmio_ready = (state==IDLE), decoded from state only.
- Accept: mmio_req & mmio_ready at rising edge T latches addr, data and op.
- mmio_req while not ready is ignored; nothing is queued.
- Op priority: mmio_wr=1 means write, regardless of mmio_rd. mmio_rd=1 alone means read. Neither set is a null op.
- Write:
  - IDLE->ACCESS at T.
  - During cycle T+1: slot_cs[k]=1, slot_write=1, slot_addr and slot_wr_data valid, mmio_ack=1.
  - ACCESS->IDLE at T+1. Strobes last exactly one cycle.
- Read:
  - IDLE->ACCESS at T.
  - During T+1: slot_cs[k]=1, slot_read=1, slot_addr valid.
  - The edge ending T+1 captures slot_rd_data[k] into mmio_rd_data; ACCESS->RESP.
  - During T+2: mmio_ack=1, strobes low. RESP->IDLE.
  - Read latency is 2 cycles from accept to ack.
- Null op: ack during T+1, no slot strobe, mmio_rd_data unchanged.
- Unpopulated slot (index >= N_SLOTS):
  - slot_cs stays all-zero.
  - Write completes with ack at T+1.
  - Read returns 0 with ack at T+2.
- Throughput limits:
  - Back-to-back writes: one per 2 cycles.
  - Back-to-back reads: one per 3 cycles.
  - The earliest next accept is the ack cycle's trailing edge (state returns to IDLE).
- slot_addr and slot_wr_data hold their last values between accesses; slot_cs, slot_read and slot_write are low outside ACCESS.
- Reset mid-operation: all outputs go to reset values immediately, asynchronously. An in-flight access is dropped with no ack.

Optional Feature:
- Macro: MMIO_ERR_EN.
- Defined:
  - Extra output mmio_err (1 bit), pulsed together with mmio_ack when the accessed slot index >= N_SLOTS, or when the op is null.
  - Unpopulated reads return 32'hDEAD_BEEF instead of 0.
- Undefined:
  - No mmio_err port.
  - Unpopulated reads return 0.
  - Null ops ack silently.

Test Plan:
- Reset asserted mid-read in ACCESS -> slot_cs=0, slot_read=0, mmio_ack never pulses, mmio_ready=1, mmio_rd_data=0.
- Write slot 2, reg 2, data 32'h1 (timer go) -> cycle T+1: slot_cs=32'h4, slot_write=1, slot_addr=2, slot_wr_data=1, mmio_ack=1; cycle T+2: all strobes 0.
- Read slot 2, reg 0 with slot_rd_data[95:64]=32'h0000_1234 -> slot_read=1 at T+1; mmio_ack=1 and mmio_rd_data=32'h0000_1234 at T+2; mmio_ready=0 during T+1 and T+2.
- mmio_req pulsed every cycle with reads -> accepts only at T, T+3, T+6; intermediate requests ignored; 3 acks for 7 cycles of requests.
- Read slot 40 (N_SLOTS=32) -> slot_cs all-zero, ack at T+2 with mmio_rd_data=0, or 32'hDEAD_BEEF with mmio_err=1 under MMIO_ERR_EN.
- mmio_wr=1 and mmio_rd=1 on same req -> treated as write: slot_write=1, slot_read=0, ack at T+1.

Source files
------------

// File: rtl/mmio_slot_ctrl.sv
// mmio_slot_ctrl: registered MMIO front end that decodes the slot index and drives shared slot strobes.
// Ports: clk/reset (async, active-high); mmio_req/wr/rd/addr/wr_data in from the bus bridge;
// mmio_ready/ack/rd_data back to it; slot_cs/read/write/addr/wr_data out to the slots;
// slot_rd_data in (slot k at [32k+31:32k]). Define MMIO_ERR_EN to add the mmio_err output.
module mmio_slot_ctrl #(
  parameter int N_SLOTS = 32,
  parameter int SLOT_W = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mmio_req,
  input  logic                    mmio_wr,
  input  logic                    mmio_rd,
  input  logic [SLOT_W+4:0]       mmio_addr,
  input  logic [31:0]             mmio_wr_data,
  output logic                    mmio_ready,
  output logic                    mmio_ack,
`ifdef MMIO_ERR_EN
  output logic                    mmio_err,
`endif
  output logic [31:0]             mmio_rd_data,
  output logic [N_SLOTS-1:0]      slot_cs,
  output logic                    slot_read,
  output logic                    slot_write,
  output logic [4:0]              slot_addr,
  output logic [31:0]             slot_wr_data,
  input  logic [N_SLOTS*32-1:0]   slot_rd_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`ifdef MMIO_ERR_EN
  localparam logic [31:0] UNPOP_DATA = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] UNPOP_DATA = 32'h0;
`endif
  state_t state;
  logic [SLOT_W-1:0] req_slot, acc_slot;
  logic [N_SLOTS-1:0] req_cs;
  logic [31:0] acc_word;
  logic acc_pop, acc_rd;
  logic is_wr, is_rd;
  assign req_slot = mmio_addr[SLOT_W+4:5];
  assign acc_pop = {1'b0, acc_slot} < (SLOT_W+1)'(N_SLOTS);
  assign mmio_ready = state == IDLE;
  assign is_wr = mmio_wr;
  assign is_rd = !mmio_wr && mmio_rd;
  // Unpopulated indices match no k, so their chip select and read word stay zero.
  always_comb begin
    req_cs = '0;
    acc_word = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      req_cs[k] = req_slot == SLOT_W'(k);
      if (acc_slot == SLOT_W'(k)) acc_word = slot_rd_data[32*k +: 32];
    end
  end
`ifdef MMIO_ERR_EN
  logic req_pop;
  assign req_pop = {1'b0, req_slot} < (SLOT_W+1)'(N_SLOTS);
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc_slot <= '0;
      acc_rd <= 1'b0;
      mmio_ack <= 1'b0;
      mmio_rd_data <= '0;
      slot_cs <= '0;
      slot_read <= 1'b0;
      slot_write <= 1'b0;
      slot_addr <= '0;
      slot_wr_data <= '0;
`ifdef MMIO_ERR_EN
      mmio_err <= 1'b0;
`endif
    end else begin
      mmio_ack <= 1'b0;
      slot_cs <= '0;
      slot_read <= 1'b0;
      slot_write <= 1'b0;
`ifdef MMIO_ERR_EN
      mmio_err <= 1'b0;
`endif
      case (state)
        IDLE: if (mmio_req) begin
          state <= ACCESS;
          acc_slot <= req_slot;
          acc_rd <= is_rd;
          slot_write <= is_wr;
          slot_read <= is_rd;
          // Writes and null ops complete in the strobe cycle; reads ack one cycle later.
          mmio_ack <= !is_rd;
          if (is_wr || is_rd) begin
            slot_cs <= req_cs;
            slot_addr <= mmio_addr[4:0];
          end
          if (is_wr) slot_wr_data <= mmio_wr_data;
`ifdef MMIO_ERR_EN
          mmio_err <= (is_wr && !req_pop) || (!is_wr && !is_rd);
`endif
        end
        ACCESS: begin
          state <= acc_rd ? RESP : IDLE;
          if (acc_rd) begin
            mmio_ack <= 1'b1;
            mmio_rd_data <= acc_pop ? acc_word : UNPOP_DATA;
`ifdef MMIO_ERR_EN
            mmio_err <= !acc_pop;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
